// File: rtl/fifo_rd_packer.sv
// Packs PACK_RATIO consecutive show-ahead FIFO words into one wide valid/ready beat; flush emits a partial beat.
// Optional idle auto-flush is enabled by defining PACKER_TIMEOUT_EN.
module fifo_rd_packer #(
    parameter int DATA_WIDTH     = 8,
    parameter int PACK_RATIO     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [DATA_WIDTH-1:0]            fifo_dataout,
    input  logic                             fifo_empty,
    output logic                             pop,
    input  logic                             flush,
    output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
    output logic [$clog2(PACK_RATIO):0]      out_count,
    output logic                             out_valid,
    input  logic                             out_ready
);
    localparam int AW = $clog2(PACK_RATIO);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] LAST = AW'(PACK_RATIO - 1);
    localparam logic [0:0] S_FILL  = 1'b0;
    localparam logic [0:0] S_FLUSH = 1'b1;

    logic [PACK_RATIO-2:0][DATA_WIDTH-1:0] r_acc;
    logic [PACK_RATIO-2:0][DATA_WIDTH-1:0] w_partial;
    logic [AW-1:0]                         r_acc_cnt;
    logic [AW-1:0]                         w_acc_cnt_nxt;
    logic [0:0]                            r_state;
    logic [DATA_WIDTH*PACK_RATIO-1:0]      r_out_data;
    logic [CW-1:0]                         r_out_count;
    logic                                  r_out_valid;
    logic                                  w_slot_free;
    logic                                  w_last;
    logic                                  w_pop;
    logic                                  w_emit_partial;
    logic                                  w_flush_req;

    assign w_slot_free    = !r_out_valid || out_ready;
    assign w_last         = (r_acc_cnt == LAST);
    assign w_pop          = !reset && (r_state == S_FILL) && !fifo_empty && (!w_last || w_slot_free);
    assign w_emit_partial = (r_state == S_FLUSH) && w_slot_free;

    assign pop       = w_pop;
    assign out_data  = r_out_data;
    assign out_count = r_out_count;
    assign out_valid = r_out_valid;

    always_comb begin
        w_acc_cnt_nxt = r_acc_cnt;
        if (w_pop)
            w_acc_cnt_nxt = w_last ? '0 : r_acc_cnt + 1'b1;
        else if (w_emit_partial)
            w_acc_cnt_nxt = '0;
    end

    // Lanes beyond the fill count may hold stale words from an earlier beat.
    always_comb begin
        w_partial = '0;
        for (int i = 0; i < PACK_RATIO - 1; i++)
            if (AW'(i) < r_acc_cnt)
                w_partial[i] = r_acc[i];
    end

`ifdef PACKER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_idle;
    logic          w_timeout;

    assign w_timeout   = (r_idle == TW'(TIMEOUT_CYCLES));
    assign w_flush_req = flush || w_timeout;

    always_ff @(posedge clock) begin
        if (reset || r_acc_cnt == '0 || w_pop || w_timeout)
            r_idle <= '0;
        else
            r_idle <= r_idle + 1'b1;
    end
`else
    assign w_flush_req = flush;
`endif

    always_ff @(posedge clock) begin
        for (int i = 0; i < PACK_RATIO - 1; i++)
            if (w_pop && !w_last && r_acc_cnt == AW'(i))
                r_acc[i] <= fifo_dataout;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc_cnt   <= '0;
            r_state     <= S_FILL;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
        end else begin
            r_acc_cnt <= w_acc_cnt_nxt;
            // A flush landing on the completing pop finds the count back at zero and is dropped.
            case (r_state)
                S_FILL:  if (w_flush_req && w_acc_cnt_nxt != '0) r_state <= S_FLUSH;
                default: if (w_emit_partial) r_state <= S_FILL;
            endcase
            if (w_pop && w_last) begin
                r_out_data  <= {fifo_dataout, r_acc};
                r_out_count <= CW'(PACK_RATIO);
                r_out_valid <= 1'b1;
            end else if (w_emit_partial) begin
                r_out_data  <= {{DATA_WIDTH{1'b0}}, w_partial};
                r_out_count <= {1'b0, r_acc_cnt};
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed table-driven bench for fifo_rd_packer (DATA_WIDTH=8, PACK_RATIO=4).
module tb_fifo_rd_packer;
    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  fifo_dataout;
    logic        fifo_empty;
    logic        pop;
    logic        flush;
    logic [31:0] out_data;
    logic [2:0]  out_count;
    logic        out_valid;
    logic        out_ready;

    int errors = 0;
    int checks = 0;

    fifo_rd_packer #(.DATA_WIDTH(8), .PACK_RATIO(4), .TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .reset(reset), .fifo_dataout(fifo_dataout), .fifo_empty(fifo_empty),
        .pop(pop), .flush(flush), .out_data(out_data), .out_count(out_count),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clock = ~clock;

    // One record per cycle: inputs, then pop and the registered outputs seen before that cycle's edge.
    typedef struct {
        logic        rst, emp;
        logic [7:0]  din;
        logic        fl, rdy;
        logic        e_pop, e_vld;
        logic [31:0] e_data;
        logic [2:0]  e_cnt;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(logic rst, logic emp, logic [7:0] din, logic fl, logic rdy,
                                logic p, logic v, logic [31:0] d, logic [2:0] c);
        vec_t t;
        t = '{rst, emp, din, fl, rdy, p, v, d, c};
        tbl.push_back(t);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(logic rst, logic emp, logic [7:0] din, logic fl, logic rdy);
        @(negedge clock);
        reset = rst; fifo_empty = emp; fifo_dataout = din; flush = fl; out_ready = rdy;
        #1;
    endtask

    task automatic chk_out(string tag, logic p, logic v, logic [31:0] d, logic [2:0] c);
        chk({tag, ".pop"}, {31'b0, pop}, {31'b0, p});
        chk({tag, ".valid"}, {31'b0, out_valid}, {31'b0, v});
        chk({tag, ".data"}, out_data, d);
        chk({tag, ".count"}, {29'b0, out_count}, {29'b0, c});
    endtask

    initial begin
        reset = 1'b1; fifo_empty = 1'b1; fifo_dataout = '0; flush = 1'b0; out_ready = 1'b1;

        // reset state
        add(1,0,8'h99,0,1, 0,0,32'h0,0);
        // full beat
        add(0,0,8'h11,0,1, 1,0,32'h0,0);
        add(0,0,8'h22,0,1, 1,0,32'h0,0);
        add(0,0,8'h33,0,1, 1,0,32'h0,0);
        add(0,0,8'h44,0,1, 1,0,32'h0,0);
        add(0,1,8'h00,0,1, 0,1,32'h44332211,4);
        add(0,1,8'h00,0,1, 0,0,32'h44332211,4);
        // backpressure
        add(0,0,8'h01,0,0, 1,0,32'h44332211,4);
        add(0,0,8'h02,0,0, 1,0,32'h44332211,4);
        add(0,0,8'h03,0,0, 1,0,32'h44332211,4);
        add(0,0,8'h04,0,0, 1,0,32'h44332211,4);
        add(0,0,8'h05,0,0, 1,1,32'h04030201,4);
        add(0,0,8'h06,0,0, 1,1,32'h04030201,4);
        add(0,0,8'h07,0,0, 1,1,32'h04030201,4);
        add(0,0,8'h08,0,0, 0,1,32'h04030201,4);
        add(0,0,8'h08,0,0, 0,1,32'h04030201,4);
        add(0,0,8'h08,0,1, 1,1,32'h04030201,4);
        add(0,1,8'h00,0,1, 0,1,32'h08070605,4);
        add(0,1,8'h00,0,1, 0,0,32'h08070605,4);
        // flush partial, then flush with empty accumulator
        add(0,0,8'hAA,0,1, 1,0,32'h08070605,4);
        add(0,0,8'hBB,0,1, 1,0,32'h08070605,4);
        add(0,1,8'h00,1,1, 0,0,32'h08070605,4);
        add(0,1,8'h00,0,1, 0,0,32'h08070605,4);
        add(0,1,8'h00,0,1, 0,1,32'h0000BBAA,2);
        add(0,1,8'h00,1,1, 0,0,32'h0000BBAA,2);
        add(0,1,8'h00,0,1, 0,0,32'h0000BBAA,2);
        add(0,1,8'h00,0,1, 0,0,32'h0000BBAA,2);
        // flush on completing pop
        add(0,0,8'hC1,0,1, 1,0,32'h0000BBAA,2);
        add(0,0,8'hC2,0,1, 1,0,32'h0000BBAA,2);
        add(0,0,8'hC3,0,1, 1,0,32'h0000BBAA,2);
        add(0,0,8'hC4,1,1, 1,0,32'h0000BBAA,2);
        add(0,1,8'h00,0,1, 0,1,32'hC4C3C2C1,4);
        add(0,1,8'h00,0,1, 0,0,32'hC4C3C2C1,4);
        add(0,1,8'h00,0,1, 0,0,32'hC4C3C2C1,4);
        // reset mid-beat
        add(0,0,8'hD1,0,1, 1,0,32'hC4C3C2C1,4);
        add(0,0,8'hD2,0,1, 1,0,32'hC4C3C2C1,4);
        add(1,0,8'hD3,0,1, 0,0,32'hC4C3C2C1,4);
        add(1,0,8'hD3,0,1, 0,0,32'h0,0);
        add(0,0,8'hE1,0,1, 1,0,32'h0,0);
        add(0,0,8'hE2,0,1, 1,0,32'h0,0);
        add(0,0,8'hE3,0,1, 1,0,32'h0,0);
        add(0,0,8'hE4,0,1, 1,0,32'h0,0);
        add(0,1,8'h00,0,1, 0,1,32'hE4E3E2E1,4);
        add(0,1,8'h00,0,1, 0,0,32'hE4E3E2E1,4);

        foreach (tbl[i]) begin
            cyc(tbl[i].rst, tbl[i].emp, tbl[i].din, tbl[i].fl, tbl[i].rdy);
            chk_out($sformatf("vec%0d", i), tbl[i].e_pop, tbl[i].e_vld, tbl[i].e_data, tbl[i].e_cnt);
        end

        // partial flush waiting behind a stalled full beat; extra flush pulses and a non-empty FIFO in FLUSH
        cyc(0,0,8'hF1,0,0); cyc(0,0,8'hF2,0,0); cyc(0,0,8'hF3,0,0); cyc(0,0,8'hF4,0,0);
        cyc(0,0,8'hF5,0,0); chk_out("bp_pop5", 1, 1, 32'hF4F3F2F1, 4);
        cyc(0,1,8'h00,1,0); chk_out("bp_flush", 0, 1, 32'hF4F3F2F1, 4);
        cyc(0,0,8'hF6,1,0); chk_out("bp_inflush", 0, 1, 32'hF4F3F2F1, 4);
        cyc(0,0,8'hF6,0,1); chk_out("bp_release", 0, 1, 32'hF4F3F2F1, 4);
        cyc(0,1,8'h00,0,1); chk_out("bp_partial", 0, 1, 32'h000000F5, 1);
        cyc(0,1,8'h00,0,1); chk_out("bp_drained", 0, 0, 32'h000000F5, 1);
        cyc(0,0,8'hF6,0,1); chk_out("bp_refill", 1, 0, 32'h000000F5, 1);
        cyc(1,1,8'h00,0,1); cyc(0,1,8'h00,0,1);
        chk_out("to_clean", 0, 0, 32'h0, 0);

        // idle timeout
        begin
            int seen_at;
            seen_at = 0;
            cyc(0,0,8'h5A,0,1);
            chk("to_pop", {31'b0, pop}, 32'd1);
            for (int n = 1; n <= 40 && seen_at == 0; n++) begin
                cyc(0,1,8'h00,0,1);
                if (out_valid) seen_at = n;
            end
`ifdef PACKER_TIMEOUT_EN
            chk("to_seen", {31'b0, seen_at != 0}, 32'd1);
            chk("to_not_early", {31'b0, seen_at > 16}, 32'd1);
            chk("to_data", out_data, 32'h0000005A);
            chk("to_count", {29'b0, out_count}, 32'd1);
`else
            chk("to_no_beat", {31'b0, seen_at != 0}, 32'd0);
            cyc(0,1,8'h00,1,1);
            cyc(0,1,8'h00,0,1);
            cyc(0,1,8'h00,0,1);
            chk_out("to_manual", 0, 1, 32'h0000005A, 1);
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
